// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register: req/ack data port, load extension, store lane steering.
// Optional MEM_PERF_CNT_EN adds saturating load/store/stall event counters.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_inp,
    input  logic        MemRead_inp,
    input  logic        MemWrite_inp,
    input  logic        MemtoReg_inp,
    input  logic        RegWrite_inp,
    input  logic [63:0] Result_inp,
    input  logic [63:0] data_inp,
    input  logic [2:0]  funct3_MEM,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_out,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [63:0] Read_Data_out,
    output logic [63:0] Result_out,
    output logic        misalign_err,
    output logic        bus_err
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0] ld_cnt,
    output logic [31:0] st_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [4:0]        r_rd, w_rd_nxt;
    logic              r_rw, w_rw_nxt;
    logic              r_m2r, w_m2r_nxt;
    logic [63:0]       r_rdata, w_rdata_nxt;
    logic [63:0]       r_res, w_res_nxt;
    logic              r_mis, w_mis_nxt;
    logic              r_bus, w_bus_nxt;

    logic [2:0]        w_off;
    logic              w_is_mem, w_aligned, w_legal, w_access, w_timeout;
    logic              w_req, w_stall;
    logic [63:0]       w_lane, w_ext;
    logic [7:0]        w_mask;

    assign w_off    = Result_inp[2:0];
    assign w_is_mem = MemRead_inp | MemWrite_inp;
    assign w_legal  = MemWrite_inp ? ~funct3_MEM[2] : (funct3_MEM != 3'b111);
    assign w_access = w_is_mem & ~flush & w_aligned & w_legal;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Natural alignment check and byte-lane size mask from the access size
    always_comb begin
        w_aligned = 1'b1;
        w_mask    = 8'h01;
        case (funct3_MEM[1:0])
            2'b00: begin w_aligned = 1'b1;              w_mask = 8'h01; end
            2'b01: begin w_aligned = ~w_off[0];          w_mask = 8'h03; end
            2'b10: begin w_aligned = (w_off[1:0] == 2'b00); w_mask = 8'h0F; end
            default: begin w_aligned = (w_off == 3'b000); w_mask = 8'hFF; end
        endcase
    end

    // Load lane select and sign/zero extension
    always_comb begin
        w_lane = mem_rdata >> {w_off, 3'b000};
        case (funct3_MEM)
            3'b000:  w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_ext = {56'b0, w_lane[7:0]};
            3'b101:  w_ext = {48'b0, w_lane[15:0]};
            3'b110:  w_ext = {32'b0, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase
    end

    // Next-state, request/stall and MEM/WB next values; bubble by default
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_rd_nxt    = '0;
        w_rw_nxt    = 1'b0;
        w_m2r_nxt   = 1'b0;
        w_rdata_nxt = '0;
        w_res_nxt   = '0;
        w_mis_nxt   = 1'b0;
        w_bus_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_is_mem && !flush) begin
                    w_mis_nxt = 1'b1;
                end else if (!flush) begin
                    w_rd_nxt  = rd_inp;
                    w_rw_nxt  = RegWrite_inp;
                    w_m2r_nxt = MemtoReg_inp;
                    w_res_nxt = Result_inp;
                end
            end
            S_WAIT: begin
                w_req = 1'b1;
                if (mem_ack) begin
                    w_rd_nxt    = rd_inp;
                    w_rw_nxt    = RegWrite_inp & ~MemWrite_inp;
                    w_m2r_nxt   = MemtoReg_inp;
                    w_res_nxt   = Result_inp;
                    w_rdata_nxt = MemRead_inp ? w_ext : 64'd0;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_timeout) begin
                    w_req       = 1'b0;
                    w_bus_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Request and stall must fall immediately while reset is held
        if (!reset) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
            r_m2r   <= 1'b0;
            r_rdata <= '0;
            r_res   <= '0;
            r_mis   <= 1'b0;
            r_bus   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= w_rd_nxt;
            r_rw    <= w_rw_nxt;
            r_m2r   <= w_m2r_nxt;
            r_rdata <= w_rdata_nxt;
            r_res   <= w_res_nxt;
            r_mis   <= w_mis_nxt;
            r_bus   <= w_bus_nxt;
        end
    end

    assign mem_req       = w_req;
    assign mem_we        = w_req & MemWrite_inp;
    assign mem_addr      = {Result_inp[63:3], 3'b000};
    assign mem_wdata     = data_inp << {w_off, 3'b000};
    assign mem_be        = w_req ? (w_mask << w_off) : 8'h00;
    assign stall_out     = w_stall;
    assign rd_out        = r_rd;
    assign RegWrite_out  = r_rw;
    assign MemtoReg_out  = r_m2r;
    assign Read_Data_out = r_rdata;
    assign Result_out    = r_res;
    assign misalign_err  = r_mis;
    assign bus_err       = r_bus;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] r_ld_cnt, r_st_cnt, r_stall_cnt;
    logic        w_acked;

    assign w_acked = (r_state == S_WAIT) & mem_ack;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_cnt    <= '0;
            r_st_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_acked && MemRead_inp && (r_ld_cnt != '1))
                r_ld_cnt <= r_ld_cnt + 32'd1;
            if (w_acked && MemWrite_inp && (r_st_cnt != '1))
                r_st_cnt <= r_st_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign ld_cnt    = r_ld_cnt;
    assign st_cnt    = r_st_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
